axi_memtest_master: RTL and testbench

AXI_MEMTEST_MASTER -- requirements
Module: axi_memtest_master

---
 rtl/axi_memtest_master.sv | 211 +++++++++++++++++++++
 tb/tb_axi_memtest_master.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_memtest_master.sv
// axi_memtest_master
//   Single-outstanding AXI4 memory-test master. Each command either writes an
//   INCR burst of address^seed patterns or reads a burst back and counts
//   response, ID, rlast-placement and (optionally) data errors.
//
//   Optional feature macro: AXI_MEMTEST_CHECK_EN
//     defined   -> read data compared against the write pattern
//     undefined -> read data ignored (no comparator)
//
// Ports
//   clk_i, rst_i                 clock, async active-high reset
//   start_i/write_i/addr_i/len_i/seed_i   command (accepted in IDLE only)
//   busy_o, done_o, error_o, err_count_o  status
//   outport_aw*/w*/b*/ar*/r*     AXI4 master channels
module axi_memtest_master #(
    parameter logic [3:0] AXI_ID = 4'h0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        write_i,
    input  logic [31:0] addr_i,
    input  logic [7:0]  len_i,
    input  logic [31:0] seed_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    output logic [15:0] err_count_o,
    output logic        outport_awvalid_o,
    output logic [31:0] outport_awaddr_o,
    output logic [3:0]  outport_awid_o,
    output logic [7:0]  outport_awlen_o,
    output logic [1:0]  outport_awburst_o,
    input  logic        outport_awready_i,
    output logic        outport_wvalid_o,
    output logic [31:0] outport_wdata_o,
    output logic [3:0]  outport_wstrb_o,
    output logic        outport_wlast_o,
    input  logic        outport_wready_i,
    input  logic        outport_bvalid_i,
    input  logic [1:0]  outport_bresp_i,
    input  logic [3:0]  outport_bid_i,
    output logic        outport_bready_o,
    output logic        outport_arvalid_o,
    output logic [31:0] outport_araddr_o,
    output logic [3:0]  outport_arid_o,
    output logic [7:0]  outport_arlen_o,
    output logic [1:0]  outport_arburst_o,
    input  logic        outport_arready_i,
    input  logic        outport_rvalid_i,
    input  logic [31:0] outport_rdata_i,
    input  logic [1:0]  outport_rresp_i,
    input  logic [3:0]  outport_rid_i,
    input  logic        outport_rlast_i,
    output logic        outport_rready_o
);
    typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE} state_t;

    state_t      state;
    logic [31:0] base_q, seed_q;
    logic [7:0]  len_q, beat_q;

    assign outport_awid_o    = AXI_ID;
    assign outport_arid_o    = AXI_ID;
    assign outport_awburst_o = 2'b01;
    assign outport_arburst_o = 2'b01;
    assign outport_wstrb_o   = 4'hF;

    function automatic logic [31:0] pattern(input logic [31:0] base, input logic [31:0] seed,
                                            input logic [7:0] k);
        return (base + {22'd0, k, 2'b00}) ^ seed;
    endfunction

    function automatic logic [15:0] sat_add(input logic [15:0] a, input logic [1:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {15'd0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    // End offset of the burst within its 4 KB page; beyond 4096 means it crosses.
    logic [12:0] end_off;
    logic        crosses;
    assign end_off = {1'b0, addr_i[11:2], 2'b00} + {2'b00, ({1'b0, len_i} + 9'd1), 2'b00};
    assign crosses = end_off > 13'd4096;

    logic b_bad, r_bad_resp, r_bad_last, r_mismatch;
    assign b_bad      = (outport_bresp_i != 2'b00) || (outport_bid_i != AXI_ID);
    assign r_bad_resp = (outport_rresp_i != 2'b00) || (outport_rid_i != AXI_ID);
    // rlast must appear on beat len and nowhere else.
    assign r_bad_last = outport_rlast_i != (beat_q == len_q);
`ifdef AXI_MEMTEST_CHECK_EN
    assign r_mismatch = outport_rdata_i != pattern(base_q, seed_q, beat_q);
`else
    logic unused_rdata;
    assign unused_rdata = ^outport_rdata_i;
    assign r_mismatch   = 1'b0;
`endif

    // One read beat can carry up to three independent errors.
    logic [1:0]  err_inc;
    logic [15:0] err_next;
    always_comb begin
        err_inc = 2'd0;
        if (state == S_B)
            err_inc = {1'b0, b_bad};
        else if (state == S_R)
            err_inc = {1'b0, r_bad_resp} + {1'b0, r_bad_last} + {1'b0, r_mismatch};
    end
    assign err_next = sat_add(err_count_o, err_inc);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state             <= S_IDLE;
            base_q            <= '0;
            seed_q            <= '0;
            len_q             <= '0;
            beat_q            <= '0;
            busy_o            <= 1'b0;
            done_o            <= 1'b0;
            error_o           <= 1'b0;
            err_count_o       <= '0;
            outport_awvalid_o <= 1'b0;
            outport_awaddr_o  <= '0;
            outport_awlen_o   <= '0;
            outport_wvalid_o  <= 1'b0;
            outport_wdata_o   <= '0;
            outport_wlast_o   <= 1'b0;
            outport_bready_o  <= 1'b0;
            outport_arvalid_o <= 1'b0;
            outport_araddr_o  <= '0;
            outport_arlen_o   <= '0;
            outport_rready_o  <= 1'b0;
        end else begin
            done_o <= 1'b0;
            case (state)
                S_IDLE: if (start_i) begin
                    base_q      <= {addr_i[31:2], 2'b00};
                    len_q       <= len_i;
                    seed_q      <= seed_i;
                    beat_q      <= '0;
                    busy_o      <= 1'b1;
                    error_o     <= 1'b0;
                    err_count_o <= '0;
                    if (crosses) begin
                        err_count_o <= 16'd1;
                        error_o     <= 1'b1;
                        done_o      <= 1'b1;
                        state       <= S_DONE;
                    end else if (write_i) begin
                        outport_awvalid_o <= 1'b1;
                        outport_awaddr_o  <= {addr_i[31:2], 2'b00};
                        outport_awlen_o   <= len_i;
                        state             <= S_AW;
                    end else begin
                        outport_arvalid_o <= 1'b1;
                        outport_araddr_o  <= {addr_i[31:2], 2'b00};
                        outport_arlen_o   <= len_i;
                        state             <= S_AR;
                    end
                end
                S_AW: if (outport_awready_i) begin
                    outport_awvalid_o <= 1'b0;
                    outport_wvalid_o  <= 1'b1;
                    outport_wdata_o   <= pattern(base_q, seed_q, 8'd0);
                    outport_wlast_o   <= (len_q == 8'd0);
                    state             <= S_W;
                end
                S_W: if (outport_wready_i) begin
                    if (outport_wlast_o) begin
                        outport_wvalid_o <= 1'b0;
                        outport_wlast_o  <= 1'b0;
                        outport_bready_o <= 1'b1;
                        state            <= S_B;
                    end else begin
                        beat_q          <= beat_q + 8'd1;
                        outport_wdata_o <= pattern(base_q, seed_q, beat_q + 8'd1);
                        outport_wlast_o <= ((beat_q + 8'd1) == len_q);
                    end
                end
                S_B: if (outport_bvalid_i) begin
                    outport_bready_o <= 1'b0;
                    err_count_o      <= err_next;
                    error_o          <= (err_next != 16'd0);
                    done_o           <= 1'b1;
                    state            <= S_DONE;
                end
                S_AR: if (outport_arready_i) begin
                    outport_arvalid_o <= 1'b0;
                    outport_rready_o  <= 1'b1;
                    beat_q            <= '0;
                    state             <= S_R;
                end
                S_R: if (outport_rvalid_i) begin
                    err_count_o <= err_next;
                    beat_q      <= beat_q + 8'd1;
                    if (outport_rlast_i) begin
                        outport_rready_o <= 1'b0;
                        error_o          <= (err_next != 16'd0);
                        done_o           <= 1'b1;
                        state            <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy_o <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_memtest_master.sv
// Self-checking bench for axi_memtest_master. Inputs are driven and outputs
// sampled on the falling clock edge; the DUT registers on the rising edge.
module tb_axi_memtest_master;
    localparam int LIMIT = 2000;
`ifdef AXI_MEMTEST_CHECK_EN
    localparam int READ_EXP_ERR = 1;
`else
    localparam int READ_EXP_ERR = 0;
`endif

    logic clk = 1'b0, rst = 1'b1;
    logic start = 1'b0, write = 1'b0;
    logic [31:0] addr = '0, seed = '0;
    logic [7:0]  len = '0;
    logic busy, done, error;
    logic [15:0] err_count;
    logic awvalid, awready = 1'b0;
    logic [31:0] awaddr; logic [3:0] awid; logic [7:0] awlen; logic [1:0] awburst;
    logic wvalid, wlast, wready = 1'b0;
    logic [31:0] wdata; logic [3:0] wstrb;
    logic bvalid = 1'b0, bready;
    logic [1:0] bresp = '0; logic [3:0] bid = '0;
    logic arvalid, arready = 1'b0;
    logic [31:0] araddr; logic [3:0] arid; logic [7:0] arlen; logic [1:0] arburst;
    logic rvalid = 1'b0, rlast = 1'b0, rready;
    logic [31:0] rdata = '0; logic [1:0] rresp = '0; logic [3:0] rid = '0;

    int vectors = 0, miscompares = 0;
    int done_cnt = 0, done_cyc = 0, cyc_g = 0, av_cnt = 0, ar_cnt = 0, ovl_cnt = 0, start_cyc = 0;
    logic [31:0] exp_q[$], got_w[$];
    logic        got_l[$];
    logic [31:0] aw_addr_seen; logic [7:0] aw_len_seen; logic [1:0] aw_burst_seen;
    logic [3:0]  wstrb_seen;

    axi_memtest_master #(.AXI_ID(4'h0)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .write_i(write), .addr_i(addr),
        .len_i(len), .seed_i(seed), .busy_o(busy), .done_o(done), .error_o(error),
        .err_count_o(err_count),
        .outport_awvalid_o(awvalid), .outport_awaddr_o(awaddr), .outport_awid_o(awid),
        .outport_awlen_o(awlen), .outport_awburst_o(awburst), .outport_awready_i(awready),
        .outport_wvalid_o(wvalid), .outport_wdata_o(wdata), .outport_wstrb_o(wstrb),
        .outport_wlast_o(wlast), .outport_wready_i(wready),
        .outport_bvalid_i(bvalid), .outport_bresp_i(bresp), .outport_bid_i(bid),
        .outport_bready_o(bready),
        .outport_arvalid_o(arvalid), .outport_araddr_o(araddr), .outport_arid_o(arid),
        .outport_arlen_o(arlen), .outport_arburst_o(arburst), .outport_arready_i(arready),
        .outport_rvalid_i(rvalid), .outport_rdata_i(rdata), .outport_rresp_i(rresp),
        .outport_rid_i(rid), .outport_rlast_i(rlast), .outport_rready_o(rready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_g++;
    always @(negedge clk) begin
        if (done) begin done_cnt++; done_cyc = cyc_g; end
        if (awvalid || arvalid) av_cnt++;
        if (arvalid) ar_cnt++;
        if (int'(awvalid) + int'(wvalid) + int'(arvalid) > 1) ovl_cnt++;
    end

    function automatic logic [31:0] pat(input logic [31:0] a, input logic [31:0] s, input int k);
        return (a + 32'(4 * k)) ^ s;
    endfunction

    task automatic issue(input logic w, input logic [31:0] a, input logic [7:0] l, input logic [31:0] s);
        @(negedge clk);
        write = w; addr = a; len = l; seed = s; start = 1'b1;
        start_cyc = cyc_g;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Write-side slave: records AW fields and W beats, flags any change of
    // address/data while the master is stalled, then returns one B response.
    task automatic serve_write(input int aw_delay, input bit toggle, input logic [1:0] resp,
                               output int hs, output int unstable);
        int cyc = 0, aw_wait = 0;
        bit aw_done = 0, last_seen = 0, b_hs = 0, fin = 0, stall = 0;
        logic [31:0] prev_data = '0;
        logic prev_last = 1'b0;
        hs = 0; unstable = 0;
        got_w.delete(); got_l.delete();
        while (!fin && cyc < LIMIT) begin
            @(negedge clk); cyc++;
            awready = 1'b0;
            if (b_hs) begin
                bvalid = 1'b0; fin = 1;
            end else begin
                if (!aw_done && awvalid) begin
                    if (aw_wait == 0) begin
                        aw_addr_seen = awaddr; aw_len_seen = awlen; aw_burst_seen = awburst;
                    end else if (awaddr !== aw_addr_seen || awlen !== aw_len_seen) unstable++;
                    if (aw_wait >= aw_delay) begin awready = 1'b1; aw_done = 1; end
                    aw_wait++;
                end
                if (last_seen) begin
                    bvalid = 1'b1; bresp = resp; bid = 4'h0;
                    if (bready) b_hs = 1;
                end
                if (wvalid) begin
                    if (stall && (wdata !== prev_data || wlast !== prev_last)) unstable++;
                    wready = toggle ? ((cyc % 2) == 0) : 1'b1;
                    if (wready) begin
                        got_w.push_back(wdata); got_l.push_back(wlast);
                        wstrb_seen = wstrb; hs++; stall = 0;
                        if (wlast) last_seen = 1;
                    end else begin
                        stall = 1; prev_data = wdata; prev_last = wlast;
                    end
                end else wready = 1'b0;
            end
        end
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    endtask

    // Read-side slave: returns pattern data, optionally corrupting one beat,
    // with rlast on beat last_beat; stops after the rlast beat handshakes.
    task automatic serve_read(input logic [31:0] base, input logic [31:0] s, input int corrupt,
                              input int last_beat, output int beats);
        int cyc = 0, ars = 0, k = 0;
        bit hs = 0, fin = 0;
        beats = 0;
        while (!fin && cyc < LIMIT) begin
            @(negedge clk); cyc++;
            arready = 1'b0;
            if (hs) begin
                beats++; hs = 0;
                if (k == last_beat) begin rvalid = 1'b0; rlast = 1'b0; fin = 1; end
                k++;
            end
            if (!fin) begin
                if (ars == 1) ars = 2;
                if (ars == 0 && arvalid) begin
                    arready = 1'b1; ars = 1;
                end else if (ars == 2) begin
                    rvalid = 1'b1; rresp = 2'b00; rid = 4'h0;
                    rdata  = pat(base, s, k) ^ ((k == corrupt) ? 32'h10 : 32'h0);
                    rlast  = (k == last_beat);
                    if (rready) hs = 1;
                end
            end
        end
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        vectors++;
        if ({busy, done, error, awvalid, wvalid, bready, arvalid, rready} !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b want 00000000",
                     {busy, done, error, awvalid, wvalid, bready, arvalid, rready});
        end
        vectors++;
        if (err_count !== 16'h0) begin
            miscompares++; $display("FAIL reset_errcnt: got %h want 0000", err_count);
        end
        vectors++;
        if ({awaddr, wdata, araddr} !== 96'h0) begin
            miscompares++; $display("FAIL reset_data: awaddr %h wdata %h araddr %h want 0", awaddr, wdata, araddr);
        end
        rst = 1'b0;
    endtask

    task automatic test_write_basic();
        int hs, unst, d0;
        logic [31:0] e;
        d0 = done_cnt;
        for (int k = 0; k <= 3; k++) exp_q.push_back(pat(32'h100, 32'h0, k));
        issue(1'b1, 32'h100, 8'd3, 32'h0);
        serve_write(0, 1'b0, 2'b00, hs, unst);
        repeat (2) @(negedge clk);
        vectors++;
        if (aw_addr_seen !== 32'h100 || aw_len_seen !== 8'd3) begin
            miscompares++; $display("FAIL wr_aw: addr %h len %0d want 100/3", aw_addr_seen, aw_len_seen);
        end
        vectors++;
        if (aw_burst_seen !== 2'b01 || wstrb_seen !== 4'hF) begin
            miscompares++; $display("FAIL wr_burst_strb: burst %b strb %h want 01/F", aw_burst_seen, wstrb_seen);
        end
        vectors++;
        if (hs !== 4) begin miscompares++; $display("FAIL wr_beats: got %0d want 4", hs); end
        for (int k = 0; k <= 3; k++) begin
            e = exp_q.pop_front();
            vectors++;
            if (got_w.size() == 0) begin
                miscompares++; $display("FAIL wr_data%0d: no beat want %h", k, e);
            end else if (got_w[0] !== e || got_l[0] !== (k == 3)) begin
                miscompares++;
                $display("FAIL wr_data%0d: got %h last %b want %h last %b", k, got_w[0], got_l[0], e, k == 3);
            end
            if (got_w.size() != 0) begin void'(got_w.pop_front()); void'(got_l.pop_front()); end
        end
        vectors++;
        if (done_cnt - d0 !== 1 || error !== 1'b0 || err_count !== 16'h0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL wr_status: dones %0d err %b cnt %h busy %b want 1/0/0000/0", done_cnt - d0, error, err_count, busy);
        end
    endtask

    task automatic test_read_check();
        int beats, d0;
        d0 = done_cnt;
        issue(1'b0, 32'h100, 8'd3, 32'hA5A5A5A5);
        serve_read(32'h100, 32'hA5A5A5A5, 2, 3, beats);
        repeat (2) @(negedge clk);
        vectors++;
        if (beats !== 4) begin miscompares++; $display("FAIL rd_beats: got %0d want 4", beats); end
        vectors++;
        if (err_count !== 16'(READ_EXP_ERR) || error !== (READ_EXP_ERR != 0) || done_cnt - d0 !== 1) begin
            miscompares++;
            $display("FAIL rd_corrupt: cnt %0d err %b dones %0d want %0d/%0d/1", err_count, error, done_cnt - d0,
                     READ_EXP_ERR, READ_EXP_ERR);
        end
    endtask

    task automatic test_read_early_last();
        int beats, d0;
        d0 = done_cnt;
        issue(1'b0, 32'h40, 8'd3, 32'h5A);
        serve_read(32'h40, 32'h5A, -1, 1, beats);
        repeat (2) @(negedge clk);
        vectors++;
        if (beats !== 2 || err_count !== 16'd1 || error !== 1'b1 || done_cnt - d0 !== 1) begin
            miscompares++;
            $display("FAIL rd_early_last: beats %0d cnt %0d err %b dones %0d want 2/1/1/1", beats, err_count, error,
                     done_cnt - d0);
        end
    endtask

    task automatic test_backpressure();
        int hs, unst, d0, bad;
        logic [31:0] e;
        d0 = done_cnt; bad = 0;
        for (int k = 0; k <= 7; k++) exp_q.push_back(pat(32'h400, 32'hDEADBEEF, k));
        issue(1'b1, 32'h400, 8'd7, 32'hDEADBEEF);
        serve_write(5, 1'b1, 2'b00, hs, unst);
        repeat (2) @(negedge clk);
        vectors++;
        if (hs !== 8 || unst !== 0) begin
            miscompares++; $display("FAIL bp_handshake: beats %0d unstable %0d want 8/0", hs, unst);
        end
        for (int k = 0; k <= 7; k++) begin
            e = exp_q.pop_front();
            if (got_w.size() == 0 || got_w[0] !== e || got_l[0] !== (k == 7)) bad++;
            if (got_w.size() != 0) begin void'(got_w.pop_front()); void'(got_l.pop_front()); end
        end
        vectors++;
        if (bad !== 0) begin miscompares++; $display("FAIL bp_data: %0d bad beats want 0", bad); end
        vectors++;
        if (done_cnt - d0 !== 1 || error !== 1'b0) begin
            miscompares++; $display("FAIL bp_done: dones %0d err %b want 1/0", done_cnt - d0, error);
        end
    endtask

    task automatic test_4k_cross();
        int d0, a0, hs, unst;
        logic [31:0] e;
        d0 = done_cnt; a0 = av_cnt;
        issue(1'b1, 32'hFF8, 8'd3, 32'h0);
        repeat (4) @(negedge clk);
        vectors++;
        if (av_cnt - a0 !== 0 || done_cnt - d0 !== 1 || done_cyc - start_cyc > 2) begin
            miscompares++;
            $display("FAIL cross4k_flow: valids %0d dones %0d latency %0d want 0/1/<=2", av_cnt - a0, done_cnt - d0,
                     done_cyc - start_cyc);
        end
        vectors++;
        if (error !== 1'b1 || err_count !== 16'd1) begin
            miscompares++; $display("FAIL cross4k_err: err %b cnt %0d want 1/1", error, err_count);
        end
        // Ends exactly on the page boundary: legal.
        d0 = done_cnt;
        for (int k = 0; k <= 3; k++) exp_q.push_back(pat(32'hFF0, 32'h0, k));
        issue(1'b1, 32'hFF0, 8'd3, 32'h0);
        serve_write(0, 1'b0, 2'b00, hs, unst);
        repeat (2) @(negedge clk);
        e = exp_q[3];
        vectors++;
        if (hs !== 4 || got_w.size() != 4 || got_w[3] !== e || error !== 1'b0 || done_cnt - d0 !== 1) begin
            miscompares++;
            $display("FAIL edge4k: beats %0d err %b dones %0d want 4/0/1", hs, error, done_cnt - d0);
        end
        exp_q.delete();
    endtask

    task automatic test_slverr_ignore();
        int hs, unst, d0, r0;
        d0 = done_cnt; r0 = ar_cnt;
        issue(1'b1, 32'h300, 8'd1, 32'h1234);
        fork
            serve_write(0, 1'b0, 2'b10, hs, unst);
            begin
                repeat (3) @(negedge clk);
                write = 1'b0; addr = 32'h0; len = 8'd0; start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        join
        repeat (4) @(negedge clk);
        vectors++;
        if (error !== 1'b1 || err_count !== 16'd1) begin
            miscompares++; $display("FAIL slverr: err %b cnt %0d want 1/1", error, err_count);
        end
        vectors++;
        if (done_cnt - d0 !== 1 || ar_cnt - r0 !== 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL start_ignored: dones %0d arvalid_cycles %0d busy %b want 1/0/0", done_cnt - d0, ar_cnt - r0, busy);
        end
    endtask

    task automatic test_reset_mid_burst();
        int hs = 0, d0;
        bit hit = 0;
        d0 = done_cnt;
        issue(1'b1, 32'h200, 8'd3, 32'h0);
        awready = 1'b1; wready = 1'b1;
        for (int c = 0; c < 50 && !hit; c++) begin
            @(negedge clk);
            if (wvalid) begin
                if (hs == 2) begin rst = 1'b1; hit = 1; end
                else hs++;
            end
        end
        awready = 1'b0; wready = 1'b0;
        #1;
        vectors++;
        if (hit !== 1'b1 || wvalid !== 1'b0 || busy !== 1'b0 || wdata !== 32'h0) begin
            miscompares++;
            $display("FAIL rst_mid: reached %b wvalid %b busy %b wdata %h want 1/0/0/0", hit, wvalid, busy, wdata);
        end
        if (!hit) rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        vectors++;
        if (done_cnt - d0 !== 0) begin
            miscompares++; $display("FAIL rst_no_done: dones %0d want 0", done_cnt - d0);
        end
        test_write_basic();
    endtask

    task automatic test_protocol();
        vectors++;
        if (ovl_cnt !== 0) begin
            miscompares++; $display("FAIL valid_overlap: got %0d cycles want 0", ovl_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_write_basic();
        test_read_check();
        test_read_early_last();
        test_backpressure();
        test_4k_cross();
        test_slverr_ignore();
        test_reset_mid_burst();
        test_protocol();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
